// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared MIPS decode constants and the mult/div sequencer state
//             type, used by the hazard controller and its mult/div timer.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] FUNCT_JR    = 6'h08;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // True for any R-type funct that launches the mult/div unit.
    function automatic logic is_md_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_if
//  Purpose  : Bundles the ID/EX hazard inputs and the pipeline control
//             outputs of the hazard controller.
//  Ports    : master = pipeline side (drives ID/EX status, reads controls)
//             slave  = hazard controller (reads status, drives controls)
//  Revision : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
    logic [31:0] id_instruction;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_jump_register;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        muldiv_start;
    logic        muldiv_is_div;
    logic        muldiv_busy;
    logic        muldiv_done;
    logic [31:0] stall_count;

    modport master (
        output id_instruction, ex_mem_read, ex_rt, ex_jump_register,
        input  pc_en, ifid_en, ifid_flush, idex_bubble,
               muldiv_start, muldiv_is_div, muldiv_busy, muldiv_done, stall_count
    );

    modport slave (
        input  id_instruction, ex_mem_read, ex_rt, ex_jump_register,
        output pc_en, ifid_en, ifid_flush, idex_bubble,
               muldiv_start, muldiv_is_div, muldiv_busy, muldiv_done, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_muldiv_timer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_timer
//  Purpose  : Two-state sequencer for the multi-cycle mult/div unit. Issues
//             the op, counts its latency and flags busy/done.
//  Ports    : clk, rst_n      clock, async active-low reset
//             md_op_i         mult/div decoded in ID
//             is_div_i        decoded op is div/divu
//             lu_i, jr_i      load-use hazard / JR flush block issue
//             start_o         1-cycle launch pulse
//             is_div_o        op type, valid with start_o
//             busy_o          op in flight (registered state)
//             done_o          1-cycle pulse, HI/LO written
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_timer
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_op_i,
    input  logic is_div_i,
    input  logic lu_i,
    input  logic jr_i,
    output logic start_o,
    output logic is_div_o,
    output logic busy_o,
    output logic done_o
);

    // Counter holds cycles-remaining minus one, so the done cycle is cnt==0.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start, done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        done    = 1'b0;
        case (state_q)
            RUN: begin
                if (md_op_i && !lu_i && !jr_i) begin
                    start   = 1'b1;
                    state_d = MD_BUSY;
                    cnt_d   = is_div_i ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                // Always return to RUN after done: a waiting op issues next cycle.
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // start depends on live ID inputs, so gate it while reset is held.
    assign start_o  = start & rst_n;
    assign is_div_o = start_o & is_div_i;
    assign busy_o   = (state_q == MD_BUSY);
    assign done_o   = done;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : 5-stage MIPS hazard controller. Detects load-use and HI/LO
//             hazards, flushes on JR in EX, sequences mult/div and counts
//             stall cycles (saturating).
//  Ports    : clk    clock, rising edge
//             rst_n  async active-low reset
//             bus    pipeline_hazard_ctrl_if.slave (ID/EX status in,
//                    PC/IF-ID/ID-EX controls, mult/div controls, stall count out)
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt;
    logic        rtype, md_op, hilo_rd, is_div;
    logic        lu, hs, stall, busy;
    logic [31:0] stall_count_q, stall_count_d;
    logic        unused_ok;

    assign opcode    = bus.id_instruction[31:26];
    assign rs        = bus.id_instruction[25:21];
    assign rt        = bus.id_instruction[20:16];
    assign funct     = bus.id_instruction[5:0];
    assign unused_ok = ^bus.id_instruction[15:6];

    assign rtype   = (opcode == OP_RTYPE);
    assign md_op   = rtype & is_md_funct(funct);
    assign hilo_rd = rtype & ((funct == FUNCT_MFHI) | (funct == FUNCT_MFLO));
    assign is_div  = (funct == FUNCT_DIV) | (funct == FUNCT_DIVU);

    // $zero is never a real dependency.
    assign lu = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                ((bus.ex_rt == rs) | (bus.ex_rt == rt));
    assign hs = busy & (hilo_rd | md_op);
    // A JR flush discards the ID instruction, so it overrides any stall.
    assign stall = ~bus.ex_jump_register & (lu | hs);

    muldiv_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_op_i  (md_op),
        .is_div_i (is_div),
        .lu_i     (lu),
        .jr_i     (bus.ex_jump_register),
        .start_o  (bus.muldiv_start),
        .is_div_o (bus.muldiv_is_div),
        .busy_o   (busy),
        .done_o   (bus.muldiv_done)
    );

    // Enables are gated by rst_n so nothing advances while reset is held.
    assign bus.pc_en       = rst_n & ~stall;
    assign bus.ifid_en     = rst_n & ~stall;
    assign bus.idex_bubble = rst_n & (stall | bus.ex_jump_register);
    assign bus.ifid_flush  = rst_n & bus.ex_jump_register;
    assign bus.muldiv_busy = busy;
    assign bus.stall_count = stall_count_q;

    assign stall_count_d = (stall && (stall_count_q != 32'hFFFF_FFFF)) ?
                           stall_count_q + 32'd1 : stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl. Each cycle's
//             stimulus is queued with its expected control vector; the vector
//             is popped and compared at the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(
        .MULT_CYCLES (4),
        .DIV_CYCLES  (32),
        .CNT_W       (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector: {pc_en, ifid_en, ifid_flush, idex_bubble,
    //                   muldiv_start, muldiv_is_div, muldiv_busy, muldiv_done}
    localparam logic [7:0] V_RUN    = 8'b1100_0000;
    localparam logic [7:0] V_STALL  = 8'b0001_0000;
    localparam logic [7:0] V_FLUSH  = 8'b1111_0000;
    localparam logic [7:0] V_MSTART = 8'b1100_1000;
    localparam logic [7:0] V_DSTART = 8'b1100_1100;
    localparam logic [7:0] V_BUSY   = 8'b1100_0010;
    localparam logic [7:0] V_DONE   = 8'b1100_0011;
    localparam logic [7:0] V_HSTALL = 8'b0001_0010;
    localparam logic [7:0] V_HDONE  = 8'b0001_0011;

    localparam logic [31:0] I_NOP  = 32'h0000_0000;
    localparam logic [31:0] I_ADD  = {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] I_MULT = {6'd0, 5'd8, 5'd9, 5'd0, 5'd0, 6'h18};
    localparam logic [31:0] I_DIV  = {6'd0, 5'd8, 5'd9, 5'd0, 5'd0, 6'h1A};
    localparam logic [31:0] I_MFLO = {6'd0, 5'd0, 5'd0, 5'd11, 5'd0, 6'h12};

    typedef struct packed {
        logic [31:0] instr;
        logic        mr;
        logic [4:0]  rt;
        logic        jr;
        logic [7:0]  exp;
    } cyc_t;

    cyc_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_stall = 32'd0;

    function automatic cyc_t mk(input logic [31:0] instr, input logic mr,
                                input logic [4:0] rt, input logic jr,
                                input logic [7:0] exp);
        cyc_t c;
        c.instr = instr; c.mr = mr; c.rt = rt; c.jr = jr; c.exp = exp;
        return c;
    endfunction

    function automatic logic [7:0] obs();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
                bus.muldiv_start, bus.muldiv_is_div, bus.muldiv_busy, bus.muldiv_done};
    endfunction

    // Drives one cycle of ID/EX status and queues what the DUT must show.
    task automatic drive(input cyc_t c);
        bus.id_instruction   = c.instr;
        bus.ex_mem_read      = c.mr;
        bus.ex_rt            = c.rt;
        bus.ex_jump_register = c.jr;
        sb_q.push_back(c);
        // pc_en low in a non-reset cycle means a stall is counted.
        if (!c.exp[7] && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
    endtask

    task automatic test_reset();
        cyc_t e;
        // Hazard-creating inputs while in reset: everything must stay low.
        drive(mk(I_MULT, 1'b1, 5'd8, 1'b1, 8'h00));
        exp_stall = 32'd0;
        @(negedge clk);
        e = sb_q.pop_front();
        n_tests++;
        if (obs() !== e.exp) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", obs(), e.exp);
        end
        n_tests++;
        if (bus.stall_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_stall_count: got %h want 0", bus.stall_count);
        end
        @(posedge clk); #1;
        drive(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_RUN));
        rst_n = 1'b1;
        @(negedge clk);
        e = sb_q.pop_front();
        n_tests++;
        if (obs() !== e.exp) begin
            n_fail++; $display("FAIL reset_release: got %b want %b", obs(), e.exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        cyc_t plan[$];
        cyc_t e;
        plan.push_back(mk(I_ADD, 1'b1, 5'd8,  1'b0, V_STALL)); // rs match
        plan.push_back(mk(I_ADD, 1'b0, 5'd0,  1'b0, V_RUN));
        plan.push_back(mk(I_ADD, 1'b1, 5'd10, 1'b0, V_STALL)); // rt match
        plan.push_back(mk(I_ADD, 1'b0, 5'd8,  1'b0, V_RUN));   // not a load
        plan.push_back(mk(I_NOP, 1'b1, 5'd0,  1'b0, V_RUN));   // $zero dest
        plan.push_back(mk(I_ADD, 1'b1, 5'd3,  1'b0, V_RUN));   // no match
        foreach (plan[i]) begin
            drive(plan[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_tests++;
            if (obs() !== e.exp) begin
                n_fail++; $display("FAIL load_use cyc%0d: got %b want %b", i, obs(), e.exp);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.stall_count !== exp_stall) begin
            n_fail++; $display("FAIL load_use_count: got %0d want %0d", bus.stall_count, exp_stall);
        end
    endtask

    task automatic test_mult();
        cyc_t plan[$];
        cyc_t e;
        plan.push_back(mk(I_MULT, 1'b0, 5'd0, 1'b0, V_MSTART));
        for (int k = 0; k < 3; k++) plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_BUSY));
        plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_DONE));
        plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_RUN));
        foreach (plan[i]) begin
            drive(plan[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_tests++;
            if (obs() !== e.exp) begin
                n_fail++; $display("FAIL mult cyc%0d: got %b want %b", i, obs(), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        cyc_t plan[$];
        cyc_t e;
        plan.push_back(mk(I_MULT, 1'b0, 5'd0, 1'b0, V_MSTART));
        for (int k = 0; k < 3; k++) plan.push_back(mk(I_MULT, 1'b0, 5'd0, 1'b0, V_HSTALL));
        plan.push_back(mk(I_MULT, 1'b0, 5'd0, 1'b0, V_HDONE));
        plan.push_back(mk(I_MULT, 1'b0, 5'd0, 1'b0, V_MSTART));
        for (int k = 0; k < 3; k++) plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_BUSY));
        plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_DONE));
        plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_RUN));
        foreach (plan[i]) begin
            drive(plan[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_tests++;
            if (obs() !== e.exp) begin
                n_fail++; $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs(), e.exp);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.stall_count !== exp_stall) begin
            n_fail++; $display("FAIL back_to_back_count: got %0d want %0d", bus.stall_count, exp_stall);
        end
    endtask

    task automatic test_div_mflo();
        cyc_t plan[$];
        cyc_t e;
        plan.push_back(mk(I_DIV, 1'b0, 5'd0, 1'b0, V_DSTART));             // T
        plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_BUSY));               // T+1
        for (int k = 2; k < 32; k++) plan.push_back(mk(I_MFLO, 1'b0, 5'd0, 1'b0, V_HSTALL));
        plan.push_back(mk(I_MFLO, 1'b0, 5'd0, 1'b0, V_HDONE));             // T+32
        plan.push_back(mk(I_MFLO, 1'b0, 5'd0, 1'b0, V_RUN));               // T+33
        foreach (plan[i]) begin
            drive(plan[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_tests++;
            if (obs() !== e.exp) begin
                n_fail++; $display("FAIL div_mflo T+%0d: got %b want %b", i, obs(), e.exp);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.stall_count !== exp_stall) begin
            n_fail++; $display("FAIL div_mflo_count: got %0d want %0d", bus.stall_count, exp_stall);
        end
    endtask

    task automatic test_jr_flush();
        cyc_t plan[$];
        cyc_t e;
        plan.push_back(mk(I_ADD,  1'b1, 5'd8, 1'b1, V_FLUSH));   // flush beats load-use
        plan.push_back(mk(I_MULT, 1'b0, 5'd0, 1'b1, V_FLUSH));   // flushed mult not issued
        plan.push_back(mk(I_NOP,  1'b0, 5'd0, 1'b0, V_RUN));
        plan.push_back(mk(I_MULT, 1'b0, 5'd0, 1'b0, V_MSTART));
        plan.push_back(mk(I_NOP,  1'b0, 5'd0, 1'b0, V_BUSY));
        plan.push_back(mk(I_MFLO, 1'b0, 5'd0, 1'b1, 8'b1111_0010)); // flush while busy
        plan.push_back(mk(I_NOP,  1'b0, 5'd0, 1'b0, V_BUSY));
        plan.push_back(mk(I_NOP,  1'b0, 5'd0, 1'b0, V_DONE));    // op not cancelled
        plan.push_back(mk(I_MULT, 1'b1, 5'd8, 1'b0, V_STALL));   // load-use blocks issue
        plan.push_back(mk(I_MULT, 1'b0, 5'd0, 1'b0, V_MSTART));
        for (int k = 0; k < 3; k++) plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_BUSY));
        plan.push_back(mk(I_NOP,  1'b0, 5'd0, 1'b0, V_DONE));
        plan.push_back(mk(I_NOP,  1'b0, 5'd0, 1'b0, V_RUN));
        foreach (plan[i]) begin
            drive(plan[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_tests++;
            if (obs() !== e.exp) begin
                n_fail++; $display("FAIL jr_flush cyc%0d: got %b want %b", i, obs(), e.exp);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.stall_count !== exp_stall) begin
            n_fail++; $display("FAIL jr_flush_count: got %0d want %0d", bus.stall_count, exp_stall);
        end
    endtask

    task automatic test_reset_abort();
        cyc_t plan[$];
        cyc_t e;
        drive(mk(I_DIV, 1'b0, 5'd0, 1'b0, V_DSTART));
        @(negedge clk); e = sb_q.pop_front(); n_tests++;
        if (obs() !== e.exp) begin
            n_fail++; $display("FAIL abort_start: got %b want %b", obs(), e.exp);
        end
        @(posedge clk); #1;
        drive(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_BUSY));
        @(negedge clk); e = sb_q.pop_front(); n_tests++;
        if (obs() !== e.exp) begin
            n_fail++; $display("FAIL abort_busy: got %b want %b", obs(), e.exp);
        end
        @(posedge clk); #1;
        // T+2: reset asserted mid-op with hazard inputs present.
        drive(mk(I_MFLO, 1'b1, 5'd0, 1'b1, 8'h00));
        rst_n = 1'b0;
        exp_stall = 32'd0;
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs() !== e.exp) begin
            n_fail++; $display("FAIL abort_in_reset: got %b want %b", obs(), e.exp);
        end
        @(posedge clk); #1;
        drive(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_RUN));
        rst_n = 1'b1;
        void'(sb_q.pop_front());
        // No done pulse may appear for the aborted div.
        for (int k = 0; k < 40; k++) plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_RUN));
        foreach (plan[i]) begin
            drive(plan[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_tests++;
            if (obs() !== e.exp) begin
                n_fail++; $display("FAIL abort_after cyc%0d: got %b want %b", i, obs(), e.exp);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.stall_count !== 32'd0) begin
            n_fail++; $display("FAIL abort_count: got %0d want 0", bus.stall_count);
        end
    endtask

    task automatic test_saturate();
        cyc_t plan[$];
        cyc_t e;
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        exp_stall = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) plan.push_back(mk(I_ADD, 1'b1, 5'd8, 1'b0, V_STALL));
        plan.push_back(mk(I_NOP, 1'b0, 5'd0, 1'b0, V_RUN));
        foreach (plan[i]) begin
            drive(plan[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_tests++;
            if (obs() !== e.exp) begin
                n_fail++; $display("FAIL saturate cyc%0d: got %b want %b", i, obs(), e.exp);
            end
            if (i >= 2) begin
                n_tests++;
                if (bus.stall_count !== 32'hFFFF_FFFF) begin
                    n_fail++; $display("FAIL saturate_count cyc%0d: got %h want ffffffff", i, bus.stall_count);
                end
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.stall_count !== exp_stall) begin
            n_fail++; $display("FAIL saturate_final: got %h want %h", bus.stall_count, exp_stall);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.id_instruction   = I_NOP;
        bus.ex_mem_read      = 1'b0;
        bus.ex_rt            = 5'd0;
        bus.ex_jump_register = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_mult();
        test_back_to_back();
        test_div_mflo();
        test_jr_flush();
        test_reset_abort();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
